// File: rtl/bus_arb.sv
// Two-master round-robin arbiter sharing one slave bus between master 0 (CPU) and master 1. Optional ack watchdog: ARB_TIMEOUT_EN.
// Latency: the grant is registered one cycle after a request, so the earliest ack is 2 cycles after stb. Every transaction is followed by one IDLE cycle.
// Backpressure: a master that is not granted sees ack=0 and holds stb. A granted master waits on bus_ack (or on the forced timeout when enabled).
module bus_arb #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [21:0] m0_addr,
    input  logic [31:0] m0_dout,
    output logic [31:0] m0_din,
    output logic        m0_ack,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [21:0] m1_addr,
    input  logic [31:0] m1_dout,
    output logic [31:0] m1_din,
    output logic        m1_ack,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [21:0] bus_addr,
    output logic [31:0] bus_dout,
    input  logic [31:0] bus_din,
    input  logic        bus_ack,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last, last_nxt;   // master served most recently; the other one wins a tie
    logic   tmo_hit;          // forced termination of the current grant this cycle

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt;
    logic       gnt_stb;

    // Count consecutive granted cycles without an ack; IDLE always precedes a grant, so it clears here.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= 8'd0;
        end else if (state != IDLE && !bus_ack) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end else begin
            tmo_cnt <= 8'd0;
        end
    end

    // A real ack in the final cycle wins over the watchdog; a dropped stb is an abort, not a timeout.
    assign gnt_stb = (state == G0) ? m0_stb : ((state == G1) ? m1_stb : 1'b0);
    assign tmo_hit = gnt_stb && !bus_ack && (tmo_cnt == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    assign timeout_err = tmo_hit;

    // State and round-robin history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // Arbitration, transaction end/abort and the bus/ack steering for the current grant.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        bus_stb   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = 22'd0;
        bus_dout  = 32'd0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        m0_din    = bus_din;
        m1_din    = bus_din;
        grant     = 2'b00;
        case (state)
            IDLE: begin
                if (m0_stb && m1_stb) begin
                    state_nxt = last ? G0 : G1;
                end else if (m0_stb) begin
                    state_nxt = G0;
                end else if (m1_stb) begin
                    state_nxt = G1;
                end
            end
            G0: begin
                bus_stb  = m0_stb;
                bus_we   = m0_we;
                bus_addr = m0_addr;
                bus_dout = m0_dout;
                m0_ack   = bus_ack | tmo_hit;
                grant    = 2'b01;
                if (tmo_hit) begin
                    m0_din = 32'd0;
                end
                if (bus_ack || tmo_hit) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b0;
                end else if (!m0_stb) begin
                    state_nxt = IDLE;
                end
            end
            G1: begin
                bus_stb  = m1_stb;
                bus_we   = m1_we;
                bus_addr = m1_addr;
                bus_dout = m1_dout;
                m1_ack   = bus_ack | tmo_hit;
                grant    = 2'b10;
                if (tmo_hit) begin
                    m1_din = 32'd0;
                end
                if (bus_ack || tmo_hit) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b1;
                end else if (!m1_stb) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arb.sv
// Bench for bus_arb: two master drivers, a wait-state slave model and an ack scoreboard.
// Expected transactions are queued when a master raises stb and are checked when that master sees ack.
// Grant sequences and reset/abort behaviour are checked cycle by cycle against bench-built expectations.
module tb_bus_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_stb  [2];
    logic        m_we   [2];
    logic [21:0] m_addr [2];
    logic [31:0] m_dout [2];
    logic [31:0] m0_din, m1_din;
    logic        m0_ack, m1_ack;
    logic        bus_stb, bus_we;
    logic [21:0] bus_addr;
    logic [31:0] bus_dout, bus_din;
    logic        bus_ack;
    logic [1:0]  grant;
    logic        timeout_err;

    always #5 clk = ~clk;

    bus_arb #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .m0_stb(m_stb[0]), .m0_we(m_we[0]), .m0_addr(m_addr[0]), .m0_dout(m_dout[0]),
        .m0_din(m0_din), .m0_ack(m0_ack),
        .m1_stb(m_stb[1]), .m1_we(m_we[1]), .m1_addr(m_addr[1]), .m1_dout(m_dout[1]),
        .m1_din(m1_din), .m1_ack(m1_ack),
        .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr), .bus_dout(bus_dout),
        .bus_din(bus_din), .bus_ack(bus_ack),
        .grant(grant), .timeout_err(timeout_err)
    );

    typedef struct {
        logic        we;
        logic [21:0] addr;
        logic [31:0] dout;
        logic [31:0] din;
        logic        tmo;
    } exp_t;

    exp_t       exp_q0[$];
    exp_t       exp_q1[$];
    logic [1:0] gseq_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         ack_cnt[2];
    int         slave_wait = 0;
    int         scnt = 0;
    logic       prev_ack = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slave_data(input logic [21:0] a);
        return {10'd0, a} ^ 32'h12345638;
    endfunction

    // Slave: acks slave_wait cycles after bus_stb rises, returning address-derived data.
    always @(posedge clk) begin
        #2;
        if (bus_stb) begin
            if (scnt == slave_wait) begin
                bus_ack = 1'b1;
                bus_din = slave_data(bus_addr);
                scnt    = 0;
            end else begin
                bus_ack = 1'b0;
                bus_din = 32'hDEADBEEF;
                scnt    = scnt + 1;
            end
        end else begin
            bus_ack = 1'b0;
            bus_din = 32'hDEADBEEF;
            scnt    = 0;
        end
    end

    task automatic mon_ack(input int m);
        exp_t        e;
        logic [31:0] din;
        din = (m == 0) ? m0_din : m1_din;
        if (m == 0) begin
            if (exp_q0.size() == 0) begin
                check("m0_unexpected_ack", 0, 1);
                return;
            end
            e = exp_q0.pop_front();
        end else begin
            if (exp_q1.size() == 0) begin
                check("m1_unexpected_ack", 0, 1);
                return;
            end
            e = exp_q1.pop_front();
        end
        ack_cnt[m]++;
        check($sformatf("m%0d_ack_grant", m), 32'(grant), (m == 0) ? 32'd1 : 32'd2);
        check($sformatf("m%0d_bus_we", m), 32'(bus_we), 32'(e.we));
        check($sformatf("m%0d_bus_addr", m), 32'(bus_addr), 32'(e.addr));
        if (e.we) check($sformatf("m%0d_bus_dout", m), bus_dout, e.dout);
        else      check($sformatf("m%0d_din", m), din, e.din);
        check($sformatf("m%0d_timeout_err", m), 32'(timeout_err), 32'(e.tmo));
    endtask

    // Ack scoreboard, grant-sequence checker and post-transaction IDLE check.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_ack) check("idle_after_ack", 32'(grant), 32'd0);
            if (gseq_q.size() > 0) check("grant_seq", 32'(grant), 32'(gseq_q.pop_front()));
            if (m0_ack) mon_ack(0);
            if (m1_ack) mon_ack(1);
            if (!m0_ack && !m1_ack) check("timeout_err_quiet", 32'(timeout_err), 32'd0);
            prev_ack = m0_ack | m1_ack;
        end else begin
            prev_ack = 1'b0;
        end
    end

    // One master issuing n back-to-back transactions; lat = cycles from stb rise to ack, inclusive.
    task automatic run_master(input int m, input int n, input logic we, input logic [21:0] addr0,
                              input logic [31:0] dout0, input logic tmo, output int lat);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            int   cnt;
            logic ackd;
            @(posedge clk); #1;
            m_stb[m]  = 1'b1;
            m_we[m]   = we;
            m_addr[m] = addr0 + 22'(i);
            m_dout[m] = dout0 + 32'(i);
            e.we   = we;
            e.addr = m_addr[m];
            e.dout = m_dout[m];
            e.din  = tmo ? 32'd0 : slave_data(m_addr[m]);
            e.tmo  = tmo;
            if (m == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
            cnt  = 0;
            ackd = 1'b0;
            do begin
                @(negedge clk);
                cnt++;
                ackd = (m == 0) ? m0_ack : m1_ack;
            end while (!ackd && cnt < 60);
            if (!ackd) check($sformatf("m%0d_ack_wait", m), 32'(ackd), 32'd1);
            lat = cnt;
        end
        @(posedge clk); #1;
        m_stb[m]  = 1'b0;
        m_we[m]   = 1'b0;
        m_addr[m] = 22'd0;
        m_dout[m] = 32'd0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int l0, l1;
        rst     = 1'b1;
        bus_ack = 1'b0;
        bus_din = 32'd0;
        for (int i = 0; i < 2; i++) begin
            m_stb[i] = 1'b0; m_we[i] = 1'b0; m_addr[i] = 22'd0; m_dout[i] = 32'd0;
            ack_cnt[i] = 0;
        end
        // Reset: outputs stay 0 even with a master requesting.
        m_stb[0] = 1'b1; m_we[0] = 1'b1; m_addr[0] = 22'h1234; m_dout[0] = 32'hFFFFFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bus_stb", 32'(bus_stb), 0);
        check("rst_bus_we", 32'(bus_we), 0);
        check("rst_bus_addr", 32'(bus_addr), 0);
        check("rst_bus_dout", bus_dout, 0);
        check("rst_m0_ack", 32'(m0_ack), 0);
        check("rst_m1_ack", 32'(m1_ack), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        @(posedge clk); #1;
        m_stb[0] = 1'b0; m_we[0] = 1'b0; m_addr[0] = 22'd0; m_dout[0] = 32'd0;
        rst = 1'b0;

        // Single m0 read, slave acks 3 cycles after bus_stb.
        slave_wait = 3;
        run_master(0, 1, 1'b0, 22'h000040, 32'd0, 1'b0, l0);
        check("t1_latency", 32'(l0), 32'd5);

        // Both request one cycle after reset release: m0 first, IDLE, then m1.
        slave_wait = 0;
        do_reset();
        gseq_q = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        fork
            run_master(0, 1, 1'b0, 22'h000100, 32'd0, 1'b0, l0);
            run_master(1, 1, 1'b0, 22'h000200, 32'd0, 1'b0, l1);
        join
        check("t2_latency_m0", 32'(l0), 32'd2);
        check("t2_latency_m1", 32'(l1), 32'd4);

        // Continuous requests: strict alternation, 3 acks each.
        do_reset();
        ack_cnt[0] = 0;
        ack_cnt[1] = 0;
        gseq_q = '{2'b00, 2'b00};
        for (int i = 0; i < 3; i++) begin
            gseq_q.push_back(2'b01); gseq_q.push_back(2'b00);
            gseq_q.push_back(2'b10); gseq_q.push_back(2'b00);
        end
        fork
            run_master(0, 3, 1'b0, 22'h000300, 32'd0, 1'b0, l0);
            run_master(1, 3, 1'b0, 22'h000380, 32'd0, 1'b0, l1);
        join
        check("t3_acks_m0", 32'(ack_cnt[0]), 32'd3);
        check("t3_acks_m1", 32'(ack_cnt[1]), 32'd3);

        // m1 write.
        slave_wait = 1;
        run_master(1, 1, 1'b1, 22'h3F8000, 32'hCAFEF00D, 1'b0, l1);
        check("t4_latency", 32'(l1), 32'd3);

        // Reset in the 2nd G1 cycle, then both request: m0 wins; then m0 aborts.
        do_reset();
        slave_wait = 1000;
        @(posedge clk); #1;
        m_stb[1] = 1'b1; m_addr[1] = 22'h02AAAA;
        @(negedge clk);
        check("t5_arb_cycle", 32'(grant), 32'd0);
        @(negedge clk);
        check("t5_g1_first", 32'(grant), 32'd2);
        check("t5_g1_stb", 32'(bus_stb), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_stb[0] = 1'b1; m_addr[0] = 22'h011111;
        @(negedge clk);
        check("t5_rst_stb", 32'(bus_stb), 32'd0);
        check("t5_rst_grant", 32'(grant), 32'd0);
        @(negedge clk);
        check("t5_m0_after_rst", 32'(grant), 32'd1);
        check("t5_m0_addr", 32'(bus_addr), 32'h011111);
        @(posedge clk); #1;
        m_stb[0] = 1'b0; m_stb[1] = 1'b0;
        @(negedge clk);
        check("t5_abort_stb", 32'(bus_stb), 32'd0);
        check("t5_abort_ack", 32'(m0_ack), 32'd0);
        @(negedge clk);
        check("t5_abort_idle", 32'(grant), 32'd0);

`ifdef ARB_TIMEOUT_EN
        // Watchdog fires in the 4th G0 cycle; then a real ack in that same cycle wins.
        slave_wait = 1000;
        run_master(0, 1, 1'b0, 22'h000055, 32'd0, 1'b1, l0);
        check("t6_tmo_latency", 32'(l0), 32'd5);
        slave_wait = 3;
        run_master(0, 1, 1'b0, 22'h000056, 32'd0, 1'b0, l0);
        check("t6_ack_latency", 32'(l0), 32'd5);
`endif

        repeat (2) @(negedge clk);
        check("q0_drained", 32'(exp_q0.size()), 32'd0);
        check("q1_drained", 32'(exp_q1.size()), 32'd0);
        check("gseq_drained", 32'(gseq_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
